spike_collector: RTL and testbench

Downstream stage of the partial-sum adders in the SNN accelerator. Accepts 64-bit output-spike packets from all adders via the NoC egress port and records each spike in a 21x21 output spike map. Counts per-adder end-of-timestep markers; when every adder has reported, streams the map row-by-row to memory as packed row packets, clears it, and advances the timestep.

---
 rtl/spike_collector_pkg.sv | 36 +++
 rtl/spike_collector_if.sv | 19 +
 rtl/spike_collector_map.sv | 36 +++
 rtl/spike_collector.sv | 122 ++++++++++++
 tb/tb_spike_collector.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/spike_collector_pkg.sv
// spike_collector_pkg: shared constants for the spike collector.
// Contents: input packet layout (struct), packet type codes, the done-marker
// payload, default map size, FSM state codes, and the row-packet builder.
package spike_collector_pkg;

  localparam int PKT_W    = 64;
  localparam int COORD_W  = 5;   // x/y/row fields are 5 bits in both packet formats
  localparam int ROWB_W   = 21;  // row-bit field width in a row packet
  localparam int GRID_DEF = 21;

  localparam logic [1:0] TYPE_SPIKE  = 2'b11;
  localparam logic [1:0] TYPE_ROW    = 2'b01;
  localparam logic [9:0] DONE_MARKER = 10'h3FF;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_DRAIN   = 1'b1;

  typedef struct packed {
    logic [3:0]  dst;
    logic [3:0]  src;
    logic [1:0]  typ;
    logic [43:0] zero;
    logic [9:0]  payload;
  } in_pkt_t;

  function automatic logic [PKT_W-1:0] row_pkt(
    input logic [3:0]         dst,
    input logic [3:0]         src,
    input logic [COORD_W-1:0] row,
    input logic [7:0]         ts,
    input logic [ROWB_W-1:0]  bits
  );
    return {dst, src, TYPE_ROW, row, ts, 20'b0, bits};
  endfunction

endpackage

// File: rtl/spike_collector_if.sv
// spike_collector_if: NoC egress (in_*) and memory-side (out_*) valid/ready
// channels of the spike collector.
//   master : the NoC / memory side (drives in_valid/in_data, out_ready)
//   slave  : the collector (drives in_ready, out_valid/out_data)
interface spike_collector_if;
  import spike_collector_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [PKT_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [PKT_W-1:0] out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/spike_collector_map.sv
// spike_collector_map (module spike_map): GRID x GRID output spike bitmap.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears whole map)
//   i_set, i_x, i_y   set bit map[x][y] (caller guarantees x,y < GRID)
//   i_clr, i_clr_row  clear an entire row
//   i_rd_row          row to read; o_rd_bits = map[i_rd_row] (0 if out of range)
// Bit k of a row corresponds to column y=k.
module spike_map
  import spike_collector_pkg::*;
#(
  parameter int GRID = GRID_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_set,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_clr,
  input  logic [COORD_W-1:0] i_clr_row,
  input  logic [COORD_W-1:0] i_rd_row,
  output logic [GRID-1:0]    o_rd_bits
);
  localparam logic [COORD_W-1:0] GRID_M1 = COORD_W'(GRID - 1);

  logic [GRID-1:0][GRID-1:0] r_map;

  for (genvar r = 0; r < GRID; r++) begin : g_row
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    r_map[r] <= '0;
      else if (i_clr && i_clr_row == COORD_W'(r))    r_map[r] <= '0;
      else if (i_set && i_x == COORD_W'(r))          r_map[r][i_y] <= 1'b1;
    end
  end

  assign o_rd_bits = (i_rd_row <= GRID_M1) ? r_map[i_rd_row] : '0;
endmodule

// File: rtl/spike_collector.sv
// spike_collector: records output spikes in a GRID x GRID map, counts
// end-of-timestep markers, and once all adders reported drains the map to
// memory one row packet per handshake, clearing each row as it goes.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   bus (slave)      in_valid/in_ready/in_data  : spike packets from NoC
//                    out_valid/out_ready/out_data: row packets to memory
//   timestep         current timestep (wraps at 255)
//   timestep_done    one-cycle pulse the cycle after the last row handshake
//   err              sticky: bad packet type or out-of-range coordinate
module spike_collector
  import spike_collector_pkg::*;
#(
  parameter int         NUM_ADDERS = 7,
  parameter int         GRID       = GRID_DEF,
  parameter logic [3:0] OWN_ADDR   = 4'b1010,
  parameter logic [3:0] MEM_ADDR   = 4'b0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spike_collector_if.slave        bus,
  output logic [7:0]              timestep,
  output logic                    timestep_done,
  output logic                    err
);
  localparam int                 CW      = $clog2(NUM_ADDERS + 1);
  localparam logic [CW-1:0]      LAST_MK = CW'(NUM_ADDERS - 1);
  localparam logic [COORD_W-1:0] GRID_M1 = COORD_W'(GRID - 1);

  logic [0:0]         r_state;
  logic [CW-1:0]      r_done_cnt;
  logic [COORD_W-1:0] r_row;
  logic [7:0]         r_ts;
  logic               r_tsd, r_err, r_in_ready, r_out_valid;
  logic [PKT_W-1:0]   r_out_data;

  in_pkt_t            w_pkt;
  logic [COORD_W-1:0] w_x, w_y, w_rd_row;
  logic               w_acc, w_spk_type, w_marker, w_spike, w_bad, w_last_mk, w_out_hs;
  logic [GRID-1:0]    w_rd_bits;

  assign w_pkt      = in_pkt_t'(bus.in_data);
  assign w_x        = w_pkt.payload[9:5];
  assign w_y        = w_pkt.payload[4:0];
  assign w_acc      = bus.in_valid & r_in_ready;
  assign w_spk_type = (w_pkt.typ == TYPE_SPIKE);
  assign w_marker   = w_acc & w_spk_type & (w_pkt.payload == DONE_MARKER);
  assign w_spike    = w_acc & w_spk_type & (w_pkt.payload != DONE_MARKER)
                    & (w_x <= GRID_M1) & (w_y <= GRID_M1);
  assign w_bad      = w_acc & ~w_marker & ~w_spike;
  assign w_last_mk  = w_marker & (r_done_cnt == LAST_MK);
  assign w_out_hs   = r_out_valid & bus.out_ready;

  // Read port looks one row ahead so the next packet can be registered on
  // the current handshake; in COLLECT it points at row 0 for drain entry.
  assign w_rd_row = (r_state == ST_COLLECT) ? '0 : r_row + 1'b1;

  spike_map #(.GRID(GRID)) u_map (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_set     (w_spike),
    .i_x       (w_x),
    .i_y       (w_y),
    .i_clr     (w_out_hs),
    .i_clr_row (r_row),
    .i_rd_row  (w_rd_row),
    .o_rd_bits (w_rd_bits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_COLLECT;
      r_done_cnt  <= '0;
      r_row       <= '0;
      r_ts        <= '0;
      r_tsd       <= 1'b0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_tsd <= 1'b0;
      if (w_bad) r_err <= 1'b1;
      case (r_state)
        ST_COLLECT: begin
          if (w_last_mk) begin
            r_state     <= ST_DRAIN;
            r_done_cnt  <= '0;
            r_row       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_data  <= row_pkt(MEM_ADDR, OWN_ADDR, '0, r_ts, ROWB_W'(w_rd_bits));
          end else if (w_marker) begin
            r_done_cnt <= r_done_cnt + 1'b1;
          end
        end
        default: begin
          if (w_out_hs) begin
            if (r_row == GRID_M1) begin
              r_state     <= ST_COLLECT;
              r_row       <= '0;
              r_ts        <= r_ts + 8'd1;
              r_tsd       <= 1'b1;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
            end else begin
              r_row      <= r_row + 1'b1;
              r_out_data <= row_pkt(MEM_ADDR, OWN_ADDR, w_rd_row, r_ts, ROWB_W'(w_rd_bits));
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign timestep       = r_ts;
  assign timestep_done  = r_tsd;
  assign err            = r_err;
endmodule

// File: tb/tb_spike_collector.sv
module tb_spike_collector;
  import spike_collector_pkg::*;

  localparam int G   = 21;
  localparam int TMO = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] timestep;
  logic       timestep_done, err;
  int         checks = 0, failures = 0;
  logic [20:0] expb [G];

  spike_collector_if bus();

  spike_collector u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .timestep      (timestep),
    .timestep_done (timestep_done),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [1:0] typ, input logic [9:0] pay);
    return {4'hA, 4'h3, typ, 44'b0, pay};
  endfunction

  function automatic logic [9:0] xy(input int x, input int y);
    logic [4:0] xx, yy;
    xx = 5'(x); yy = 5'(y);
    return {xx, yy};
  endfunction

  task automatic clr_exp();
    for (int k = 0; k < G; k++) expb[k] = '0;
  endtask

  // Present a packet and hold it until accepted (bounded).
  task automatic send(input logic [63:0] p);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = p;
    n = 0;
    while (!bus.in_ready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic markers(input int n);
    for (int i = 0; i < n; i++) send(mk(TYPE_SPIKE, DONE_MARKER));
  endtask

  // Consume a whole drain, checking every row packet against expb[] and the
  // end-of-drain state. toggle=1 alternates out_ready to create stalls.
  task automatic drain(input bit toggle, input logic [7:0] ts);
    int cyc, nrows;
    bit stalled;
    logic [63:0] prev, exp;
    cyc = 0; nrows = 0; stalled = 0; prev = '0;
    while (nrows < G && cyc < TMO) begin
      @(negedge clk); cyc++;
      if (bus.out_valid) begin
        chk("in_ready_low_in_drain", {63'b0, bus.in_ready}, 64'd0);
        if (stalled) chk("stall_hold", bus.out_data, prev);
        bus.out_ready = toggle ? cyc[0] : 1'b1;
        prev = bus.out_data;
        if (bus.out_ready) begin
          exp = {4'h0, 4'hA, 2'b01, 5'(nrows), ts, 20'b0, expb[nrows]};
          chk("row_pkt", bus.out_data, exp);
          nrows++;
          stalled = 0;
        end else stalled = 1;
      end
    end
    chk("drain_rows", 64'(nrows), 64'(G));
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    chk("tsd_pulse", {63'b0, timestep_done}, 64'd1);
    chk("ts_advance", {56'b0, timestep}, {56'b0, ts + 8'd1});
    chk("in_ready_back", {63'b0, bus.in_ready}, 64'd1);
    chk("out_valid_drop", {63'b0, bus.out_valid}, 64'd0);
    @(posedge clk); #1;
    chk("tsd_one_cycle", {63'b0, timestep_done}, 64'd0);
  endtask

  initial begin
    int n;
    bit hit;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_ts", {56'b0, timestep}, 64'd0);
    chk("rst_err", {63'b0, err}, 64'd0);
    chk("rst_tsd", {63'b0, timestep_done}, 64'd0);
    rst_n = 1'b1;

    // Basic: two spikes, full drain
    clr_exp();
    send(mk(TYPE_SPIKE, xy(0, 6)));
    send(mk(TYPE_SPIKE, xy(20, 20)));
    markers(6);
    chk("no_drain_at_6", {63'b0, bus.out_valid}, 64'd0);
    markers(1);
    chk("drain_entry_valid", {63'b0, bus.out_valid}, 64'd1);
    chk("drain_entry_ready", {63'b0, bus.in_ready}, 64'd0);
    chk("drain_entry_row", 64'(bus.out_data[53:49]), 64'd0);
    expb[0] = 21'h000040; expb[20] = 21'h100000;
    drain(1'b0, 8'd0);

    // Bad coordinate and bad type: dropped, err sticky
    clr_exp();
    send(mk(TYPE_SPIKE, xy(21, 3)));
    chk("err_bad_coord", {63'b0, err}, 64'd1);
    send(mk(2'b10, xy(1, 1)));
    markers(7);
    chk("err_sticky", {63'b0, err}, 64'd1);
    drain(1'b0, 8'd1);

    // Duplicate spike is idempotent
    clr_exp();
    for (int i = 0; i < 3; i++) send(mk(TYPE_SPIKE, xy(5, 5)));
    markers(7);
    expb[5] = 21'h000020;
    drain(1'b0, 8'd2);

    // Spike between markers 6 and 7; next packet held off during drain
    clr_exp();
    markers(6);
    send(mk(TYPE_SPIKE, xy(2, 3)));
    markers(1);
    expb[2] = 21'h000008;
    fork
      send(mk(TYPE_SPIKE, xy(7, 9)));
      drain(1'b0, 8'd3);
    join
    clr_exp();
    markers(7);
    expb[7] = 21'h000200;
    drain(1'b0, 8'd4);

    // Backpressure during drain
    clr_exp();
    send(mk(TYPE_SPIKE, xy(10, 0)));
    send(mk(TYPE_SPIKE, xy(3, 20)));
    markers(7);
    expb[10] = 21'h000001; expb[3] = 21'h100000;
    drain(1'b1, 8'd5);

    // Reset in the middle of a drain (row 10)
    send(mk(TYPE_SPIKE, xy(1, 1)));
    markers(7);
    n = 0; hit = 0;
    while (!hit && n < TMO) begin
      @(negedge clk); n++;
      if (bus.out_valid && bus.out_data[53:49] == 5'd10) hit = 1;
    end
    chk("reached_row10", {63'b0, hit}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("midrst_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("midrst_ts", {56'b0, timestep}, 64'd0);
    chk("midrst_err", {63'b0, err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_exp();
    send(mk(TYPE_SPIKE, xy(4, 2)));
    markers(7);
    expb[4] = 21'h000004;
    drain(1'b0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
